// File: rtl/div_nonrestoring_33.sv
// Iterative signed divider: non-restoring, one quotient bit per cycle on a WIDTH+1 remainder.
// A start pulse reloads from any state; a zero divisor reports an exception without iterating.
module div_nonrestoring_33 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH:0]   divisor_33_inv,
  output logic [WIDTH:0]   divisor_33,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem, rem_sh, rem_step;
  logic [WIDTH-1:0] rem_fix, quo, a_abs, b_abs;
  logic [CNT_W-1:0] cnt;
  logic             sa, sb;
  logic             last_iter;

  // Magnitudes are unsigned, so -2^(WIDTH-1) maps cleanly onto 2^(WIDTH-1).
  assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign rem_step  = rem[WIDTH] ? rem_sh + divisor_33
                                : rem_sh + divisor_33_inv + {{WIDTH{1'b0}}, 1'b1};
  assign rem_fix   = rem[WIDTH] ? rem[WIDTH-1:0] + divisor_33[WIDTH-1:0] : rem[WIDTH-1:0];
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == RUN) || (state == FIX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ctrl_div) begin
      state_nxt = (data_operandB == '0) ? ZERO : RUN;
    end else begin
      case (state)
        RUN:     if (last_iter) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        ZERO:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem            <= '0;
      quo            <= '0;
      cnt            <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      divisor_33     <= '0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_div) begin
      sa             <= data_operandA[WIDTH-1];
      sb             <= data_operandB[WIDTH-1];
      quo            <= a_abs;
      rem            <= '0;
      cnt            <= '0;
      divisor_33     <= {1'b0, b_abs};
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      case (state)
        RUN: begin
          rem <= rem_step;
          quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          data_result    <= (sa ^ sb) ? -quo : quo;
          data_remainder <= sa ? -rem_fix : rem_fix;
          data_resultRDY <= 1'b1;
        end
        ZERO: begin
          data_result    <= '0;
          data_remainder <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_nonrestoring_33.md
Name: div_nonrestoring_33

Overview:
- Iterative signed 32-bit divider in the ALU multdiv unit.
- Non-restoring algorithm on a 33-bit partial remainder, one quotient bit per cycle.
- Consumes a 33-bit divisor and its bitwise complement, produced by the upstream 33-bit inverter. Subtraction is the complement plus carry-in 1.
- Drives the quotient, remainder and exception flags back to the processor's multdiv writeback path.

Parameters:
- WIDTH, 32, operand/result width. Partial remainder and divisor paths are WIDTH+1 bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous active-low reset
- ctrl_div  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  32  signed dividend
- data_operandB  input  32  signed divisor
- divisor_33_inv  input  33  bitwise NOT of {1'b0, abs(B)}, from the upstream inverter. Its input is this block's divisor_33 output.
- divisor_33  output  33  {1'b0, |B|} register, driven to the upstream inverter
- data_result  output  32  signed quotient, truncated toward zero
- data_remainder  output  32  signed remainder; sign follows the dividend
- data_exception  output  1  divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle pulse when outputs are valid
- busy  output  1  high while iterating

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; all registers 0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0, divisor_33=0.
- States: IDLE, RUN, FIX, DONE, ZERO.
- IDLE, ctrl_div=1 at edge E0:
  - Latch sign bits sa=A[31], sb=B[31].
  - Q=|A|, R=33'b0, divisor_33={0,|B|}, cnt=0.
  - |−2^31| = 0x80000000, held unsigned in 32 bits.
  - If B==0, go to ZERO; else go to RUN and set busy=1.
- RUN (one iteration per edge, 32 edges, E1..E32):
  - Form {R,Q} shifted left by 1.
  - If R≥0 (R[32]=0): R = R_shifted + divisor_33_inv + 1.
  - Else: R = R_shifted + divisor_33.
  - Q[0] = ~R_new[32].
  - cnt++; leave for FIX when cnt reaches WIDTH-1.
  - All arithmetic is 33-bit two's complement; carry-out is discarded.
- FIX (edge E33):
  - If R[32]=1, R = R + divisor_33.
  - Quotient = sa^sb ? −Q : Q.
  - Remainder = sa ? −R[31:0] : R[31:0].
  - Register both into data_result/data_remainder; go to DONE; busy=0.
- DONE:
  - data_resultRDY=1 for exactly this one cycle (after E33), data_exception=0.
  - Next edge returns to IDLE. Outputs hold their values until the next start.
- ZERO (divide by zero):
  - data_result=0, data_remainder=0, data_exception=1, data_resultRDY=1 for one cycle (after E1).
  - Then IDLE. data_exception clears with data_resultRDY.
- Latency: RDY is visible in the cycle after edge E33 for normal division, and after E1 for a zero divisor.
- Overflow: −2^31 / −1 gives data_result=0x80000000 (wraps), data_remainder=0, data_exception=0.
- Restart: ctrl_div=1 in any state, including RUN and FIX, aborts the current operation and reloads as in IDLE on the same edge. No RDY is issued for the aborted operation.
- Reset mid-operation returns to IDLE immediately; no RDY is produced.
- divisor_33 is stable from E0 until the next start.
- divisor_33_inv is combinational upstream and is used in the same cycle.

Test Plan:
- A=100, B=7, pulse ctrl_div -> RDY exactly 34 cycles after the start edge; result=14, remainder=2, exception=0.
- A=−100, B=7 -> result=−14 (0xFFFFFFF2), remainder=−2; A=100, B=−7 -> result=−14, remainder=2.
- A=1234, B=0 -> RDY 2 cycles after start; exception=1, result=0; exception low the following cycle.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0. Also A=0x80000000, B=1 -> result=0x80000000.
- Start A=50, B=5; at cycle 10 restart with A=9, B=4 -> single RDY 34 cycles after the second start; result=2, remainder=1.
- Start A=50, B=5; drop reset_n at cycle 15 -> all outputs 0 immediately, busy=0, no RDY after release. A fresh start A=7, B=7 yields result=1, remainder=0.
